// File: rtl/bw_divider_seq_pkg.sv
// Shared widths, limits and FSM encoding for the sequential Baugh-Wooley divider.
package bw_divider_seq_pkg;

  localparam int DW   = 12;
  localparam int VW   = 5;
  localparam int QW   = 7;
  localparam int CW   = $clog2(QW);
  localparam int QLIM = 2 ** (QW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/bw_divider_seq_step.sv
// One radix-2 restoring iteration on unsigned magnitudes.
module bw_divider_seq_step
  import bw_divider_seq_pkg::*;
(
  input  logic [VW:0]   p,
  input  logic          din,
  input  logic [VW-1:0] vmag,
  output logic [VW:0]   p_next,
  output logic          qbit
);

  logic [VW:0] shifted;
  logic        sub;

  // Shift in the next dividend bit and subtract the divisor when it fits; a bit pushed out of P always fits
  always_comb begin
    shifted = {p[VW-1:0], din};
    sub     = p[VW] | (shifted >= {1'b0, vmag});
    p_next  = sub ? (shifted - {1'b0, vmag}) : shifted;
    qbit    = sub;
  end

endmodule

// File: rtl/bw_divider_seq.sv
// Sequential restoring divider: 12-bit dividend / 5-bit divisor -> 7-bit quotient + 5-bit remainder.
module bw_divider_seq
  import bw_divider_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          T,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [VW:0]   prem;
  logic [QW-1:0] dlo;
  logic [QW-1:0] qmag;
  logic [VW-1:0] vmag;
  logic          t_r, qneg, rneg, dz, ovf_pre;

  logic          sd, sv;
  logic [DW-1:0] dmag_in;
  logic [VW-1:0] vmag_in;
  logic [VW:0]   p_next;
  logic          qbit;
  logic [QW-1:0] q_fix;
  logic [VW-1:0] r_fix;
  logic          ovf_post, err;

  bw_divider_seq_step u_step (
    .p      (prem),
    .din    (dlo[QW-1]),
    .vmag   (vmag),
    .p_next (p_next),
    .qbit   (qbit)
  );

  // Operand signs and magnitudes as seen on the accept edge; -2048 maps to magnitude 2048 without wrap
  always_comb begin
    sd      = T & dividend[DW-1];
    sv      = T & divisor[VW-1];
    dmag_in = sd ? (-dividend) : dividend;
    vmag_in = sv ? (-divisor) : divisor;
  end

  // Next-state logic: run a fixed number of iterations whatever the operands
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Latch operands on accept, then shift one quotient bit per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      prem    <= '0;
      dlo     <= '0;
      qmag    <= '0;
      vmag    <= '0;
      t_r     <= 1'b0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      dz      <= 1'b0;
      ovf_pre <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            t_r     <= T;
            qneg    <= sd ^ sv;
            rneg    <= sd;
            vmag    <= vmag_in;
            prem    <= {1'b0, dmag_in[DW-1:QW]};
            dlo     <= dmag_in[QW-1:0];
            qmag    <= '0;
            cnt     <= CW'(QW - 1);
            dz      <= (divisor == '0);
            ovf_pre <= (dmag_in[DW-1:QW] >= vmag_in);
          end
        end
        RUN: begin
          prem <= p_next;
          dlo  <= {dlo[QW-2:0], 1'b0};
          qmag <= {qmag[QW-2:0], qbit};
          cnt  <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sign correction and signed range check applied in FIX (truncating division, remainder follows dividend)
  always_comb begin
    q_fix    = qneg ? (-qmag) : qmag;
    r_fix    = rneg ? (-prem[VW-1:0]) : prem[VW-1:0];
    ovf_post = t_r & (qneg ? (qmag > QW'(QLIM)) : (qmag > QW'(QLIM - 1)));
    err      = dz | ovf_pre | ovf_post;
  end

  // Registered outputs: results change only on the edge that raises done
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == FIX);
      if (state == FIX) begin
        quotient    <= err ? '0 : q_fix;
        remainder   <= err ? '0 : r_fix;
        div_by_zero <= dz;
        overflow    <= ~dz & (ovf_pre | ovf_post);
      end
    end
  end

endmodule
